fp_add_sequencer: RTL and testbench

//  Multi-cycle FP32 (IEEE-754 single) adder controller for the floating-point adder subsystem.
//  - Accepts one operand pair per transaction over a valid/ready handshake.
//  - Sequences one shared iterative datapath through align, add, normalise and round.
//  - Sign resolution is internal: equal signs give signA; otherwise the larger |x| wins.
//  - Returns the packed result over a second valid/ready handshake.

---
 rtl/fp_add_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// Multi-cycle FP32 adder controller: align, add, normalise, round on one datapath.
// Define FPADD_SEQ_RNE_EN for round-to-nearest-even; otherwise ROUND truncates.
module fp_add_sequencer #(
    parameter int SHIFT_STEP = 4,
    parameter int MAX_ALIGN  = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    localparam logic [7:0]  STEP = 8'(SHIFT_STEP);
    localparam logic [7:0]  MAXD = 8'(MAX_ALIGN);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} stateT;
    stateT state;

    logic        sign;
    logic        sameSign;
    logic        special;
    logic [8:0]  expA;
    logic [7:0]  dRem;
    logic [27:0] mA;
    logic [26:0] mB;

    logic [30:0] magA, magB;
    logic [26:0] wideA, wideB;
    logic        swap;

    always_comb begin
        magA  = (op_a[30:23] == 8'd0) ? 31'd0 : op_a[30:0];
        magB  = (op_b[30:23] == 8'd0) ? 31'd0 : op_b[30:0];
        wideA = (op_a[30:23] == 8'd0) ? 27'd0 : {1'b1, op_a[22:0], 3'b000};
        wideB = (op_b[30:23] == 8'd0) ? 27'd0 : {1'b1, op_b[22:0], 3'b000};
        swap  = magB > magA;
    end

    logic [7:0]  sh;
    logic [26:0] lostMask;
    logic [26:0] alignB;

    // bits falling off the bottom of B fold into the sticky position
    always_comb begin
        sh       = (dRem < STEP) ? dRem : STEP;
        lostMask = ~({27{1'b1}} << sh);
        alignB   = (mB >> sh) | {26'd0, |(mB & lostMask)};
    end

    logic [27:0] addRes;
    assign addRes = sameSign ? mA + {1'b0, mB} : mA - {1'b0, mB};

    logic        inc;
    logic [24:0] rnd;
    logic [22:0] rMant;
    logic [8:0]  rExp;
    logic [31:0] rounded;

    always_comb begin
`ifdef FPADD_SEQ_RNE_EN
        inc = mA[2] & (mA[1] | mA[0] | mA[3]);
`else
        inc = 1'b0;
`endif
        rnd = {1'b0, mA[26:3]} + {24'd0, inc};
        if (rnd[24]) begin
            rMant = rnd[23:1];
            rExp  = expA + 9'd1;
        end else begin
            rMant = rnd[22:0];
            rExp  = expA;
        end
        rounded = (rExp >= 9'd255) ? {sign, 8'hFF, 23'd0}
                                   : {sign, rExp[7:0], rMant};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            sign      <= 1'b0;
            sameSign  <= 1'b0;
            special   <= 1'b0;
            expA      <= '0;
            dRem      <= '0;
            mA        <= '0;
            mB        <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= ALIGN;
                    special  <= (op_a[30:23] == 8'hFF) | (op_b[30:23] == 8'hFF);
                    sameSign <= op_a[31] == op_b[31];
                    if (swap) begin
                        sign <= op_b[31];
                        expA <= {1'b0, op_b[30:23]};
                        mA   <= {1'b0, wideB};
                        mB   <= wideA;
                        dRem <= op_b[30:23] - op_a[30:23];
                    end else begin
                        sign <= op_a[31];
                        expA <= {1'b0, op_a[30:23]};
                        mA   <= {1'b0, wideA};
                        mB   <= wideB;
                        dRem <= op_a[30:23] - op_b[30:23];
                    end
                end
                ALIGN: begin
                    if (special) begin
                        result    <= QNAN;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (dRem >= MAXD) begin
                        mB    <= {26'd0, |mB};
                        state <= ADD;
                    end else begin
                        mB   <= alignB;
                        dRem <= dRem - sh;
                        if (dRem <= STEP) state <= ADD;
                    end
                end
                ADD: begin
                    if (addRes == 28'd0) begin
                        result    <= sameSign ? {sign, 31'd0} : 32'd0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mA    <= addRes;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mA[27]) begin
                        mA    <= {1'b0, mA[27:2], mA[1] | mA[0]};
                        expA  <= expA + 9'd1;
                        state <= ROUND;
                    end else if (mA[26]) begin
                        state <= ROUND;
                    end else if (expA <= 9'd1) begin
                        result    <= {sign, 31'd0};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mA   <= {mA[26:0], 1'b0};
                        expA <= expA - 9'd1;
                        if (mA[25]) state <= ROUND;
                    end
                end
                ROUND: begin
                    result    <= rounded;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: directed corner cases, randomized operands against
// an exact-arithmetic reference, back-pressure and reset during alignment.
module tb_fp_add_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fp_add_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    // Exact integer sum of the two significands, then one normalise and round.
    function automatic logic [31:0] refAdd(input logic [31:0] x, input logic [31:0] y);
        int ex, ey, ea, eb, d, p, e;
        logic sa, sb;
        longint unsigned mx, my, ma, mb, s, m, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if (ex == 255 || ey == 255) return 32'h7FC00000;
        mx = (ex == 0) ? 64'd0 : (64'd1 << 23) | 64'(x[22:0]);
        my = (ey == 0) ? 64'd0 : (64'd1 << 23) | 64'(y[22:0]);
        if (ex > ey || (ex == ey && mx >= my)) begin
            ea = ex; ma = mx; sa = x[31]; eb = ey; mb = my; sb = y[31];
        end else begin
            ea = ey; ma = my; sa = y[31]; eb = ex; mb = mx; sb = x[31];
        end
        if (ma == 0) return (sa == sb) ? {sa, 31'd0} : 32'd0;
        d = ea - eb;
        if (d > 36) d = 36;
        s = (sa == sb) ? (ma << d) + mb : (ma << d) - mb;
        if (s == 0) return 32'd0;
        p = 63;
        while (!s[p]) p--;
        e = ea - d + p - 23;
        if (e < 1) return {sa, 31'd0};
        if (p > 23) begin
            m    = s >> (p - 23);
            rem  = s & ((64'd1 << (p - 23)) - 64'd1);
            half = 64'd1 << (p - 24);
        end else begin
            m    = s << (23 - p);
            rem  = 0;
            half = 1;
        end
`ifdef FPADD_SEQ_RNE_EN
        if (rem > half || (rem == half && m[0])) m++;
`else
        if (rem > half) m = m;
`endif
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {sa, 8'hFF, 23'd0};
        return {sa, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] randOp();
        int k;
        logic s;
        k = $urandom_range(0, 15);
        s = 1'($urandom);
        case (k)
            0: return {s, 31'd0};
            1: return {s, 8'd0, 23'($urandom)};
            2: return {s, 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
            3: return {s, 8'hFE, 23'($urandom)};
            4: return {s, 8'd1, 23'($urandom)};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic runTxn(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat, output bit seen);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        seen = out_valid;
        r = result;
        if (seen) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy);
        else passes++;
        checks++;
        if (result !== 32'd0) $display("FAIL reset result got %h want 0", result);
        else passes++;
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] ve [10];
        logic [31:0] r;
        int lat;
        bit seen;
        va[0] = 32'h3F800000; vb[0] = 32'h3F800000; ve[0] = 32'h40000000;
        va[1] = 32'h3FC00000; vb[1] = 32'hBFC00000; ve[1] = 32'h00000000;
        va[2] = 32'h4B800000; vb[2] = 32'h3F800000; ve[2] = 32'h4B800000;
        va[3] = 32'h3F800001; vb[3] = 32'h33800000;
`ifdef FPADD_SEQ_RNE_EN
        ve[3] = 32'h3F800002;
`else
        ve[3] = 32'h3F800001;
`endif
        va[4] = 32'h7F7FFFFF; vb[4] = 32'h7F7FFFFF; ve[4] = 32'h7F800000;
        va[5] = 32'h7F800000; vb[5] = 32'h3F800000; ve[5] = 32'h7FC00000;
        va[6] = 32'h40400000; vb[6] = 32'hBF800000; ve[6] = 32'h40000000;
        va[7] = 32'h3F800000; vb[7] = 32'hC0000000; ve[7] = 32'hBF800000;
        va[8] = 32'h00000001; vb[8] = 32'h3F800000; ve[8] = 32'h3F800000;
        va[9] = 32'h80000000; vb[9] = 32'h80000000; ve[9] = 32'h80000000;
        for (int i = 0; i < 10; i++) begin
            runTxn(va[i], vb[i], r, lat, seen);
            checks++;
            if (!seen || r !== ve[i])
                $display("FAIL directed[%0d] %h + %h got %h want %h", i, va[i], vb[i], r, ve[i]);
            else passes++;
            if (i == 0) begin
                checks++;
                if (lat !== 4) $display("FAIL latency 1+1 got %0d want 4", lat);
                else passes++;
            end
            if (i == 1 || i == 5) begin
                checks++;
                if (lat < 1 || lat > 2)
                    $display("FAIL short-path latency[%0d] got %0d want 1..2", i, lat);
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, want;
        int lat, e, mode;
        bit seen;
        for (int i = 0; i < 250; i++) begin
            a = randOp();
            mode = $urandom_range(0, 3);
            if (mode == 1) begin
                e = int'(a[30:23]) + int'($urandom_range(0, 2)) - 1;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                b = {~a[31], 8'(e), 23'($urandom)};
                if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0];
            end else if (mode == 2) begin
                e = int'(a[30:23]) - int'($urandom_range(0, 40));
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                b = {1'($urandom), 8'(e), 23'($urandom)};
            end else begin
                b = randOp();
            end
            want = refAdd(a, b);
            runTxn(a, b, r, lat, seen);
            checks++;
            if (!seen || r !== want)
                $display("FAIL random[%0d] %h + %h got %h want %h valid %b", i, a, b, r, want, seen);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        op_a = 32'h3F800000;
        op_b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        held = result;
        checks++;
        if (out_valid !== 1'b1 || held !== 32'h40400000)
            $display("FAIL backpressure result got %h valid %b want 40400000", held, out_valid);
        else passes++;
        in_valid = 1'b1;
        op_a = 32'h41200000;
        op_b = 32'h41200000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, held})
                $display("FAIL hold[%0d] valid %b ready %b result %h want 1 0 %h",
                         i, out_valid, in_ready, result, held);
            else passes++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100)
            $display("FAIL release ready/busy/valid got %b want 100", {in_ready, busy, out_valid});
        else passes++;
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL ignored input produced result valid %b want 0", out_valid);
        else passes++;
    endtask

    task automatic test_reset_mid_align();
        logic [31:0] r;
        int lat;
        bit seen, leaked;
        @(negedge clk);
        in_valid = 1'b1;
        op_a = 32'h4B800000;
        op_b = 32'h3F800000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL mid-align busy/ready got %b want 10", {busy, in_ready});
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, result} !== {3'b100, 32'd0})
            $display("FAIL mid-align reset ready %b valid %b busy %b result %h want 1 0 0 0",
                     in_ready, out_valid, busy, result);
        else passes++;
        leaked = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        checks++;
        if (leaked !== 1'b0) $display("FAIL partial result after reset got 1 want 0");
        else passes++;
        runTxn(32'h3F800000, 32'h3F800000, r, lat, seen);
        checks++;
        if (!seen || r !== 32'h40000000) $display("FAIL after reset 1+1 got %h want 40000000", r);
        else passes++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_align();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
